// File: rtl/bcd_serial_adder.sv
// Multi-digit BCD adder: validates operand digits, then adds one digit per clock (LSD first).
// Optional build macro BCD_SERIAL_SAT_EN saturates an overflowing sum to all nines.
module bcd_serial_adder #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_valid,
   output logic                  start_ready,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   input  logic                  cin,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [4*DIGITS-1:0]   sum,
   output logic                  cout,
   output logic                  err,
   output logic                  busy
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CHECK = 2'd1;
   localparam logic [1:0] S_ADD   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]            state;
   logic [4*DIGITS-1:0]   a_r;
   logic [4*DIGITS-1:0]   b_r;
   logic                  cin_r;
   logic                  carry;
   logic [IDX_W-1:0]      idx;
   logic [4:0]            dsum;
   logic [4*DIGITS-1:0]   sum_next;

   function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) bad = 1'b1;
      end
      return bad;
   endfunction

   function automatic logic [3:0] digit_at(input logic [4*DIGITS-1:0] v,
                                           input logic [IDX_W-1:0] k);
      logic [3:0] d;
      d = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (k == IDX_W'(i)) d = v[4*i +: 4];
      end
      return d;
   endfunction

   // Binary add with +6 correction; returns {decimal carry, digit}.
   function automatic logic [4:0] bcd_digit_add(input logic [3:0] x, input logic [3:0] y,
                                                input logic c);
      logic [4:0] t;
      logic [4:0] adj;
      t   = {1'b0, x} + {1'b0, y} + {4'b0000, c};
      adj = t + 5'd6;
      if (t > 5'd9) return {1'b1, adj[3:0]};
      return {1'b0, t[3:0]};
   endfunction

`ifdef BCD_SERIAL_SAT_EN
   function automatic logic [4*DIGITS-1:0] all_nines();
      return {DIGITS{4'h9}};
   endfunction
`endif

   assign start_ready = (state == S_IDLE);
   assign busy        = ~start_ready;

   assign dsum = bcd_digit_add(digit_at(a_r, idx), digit_at(b_r, idx), carry);

   always_comb begin
      sum_next = sum;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IDX_W'(i)) sum_next[4*i +: 4] = dsum[3:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         a_r       <= '0;
         b_r       <= '0;
         cin_r     <= 1'b0;
         carry     <= 1'b0;
         idx       <= '0;
         sum       <= '0;
         cout      <= 1'b0;
         err       <= 1'b0;
         res_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_valid) begin
                  a_r   <= a;
                  b_r   <= b;
                  cin_r <= cin;
                  sum   <= '0;
                  cout  <= 1'b0;
                  err   <= 1'b0;
                  state <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (has_bad_digit(a_r) || has_bad_digit(b_r)) begin
                  err       <= 1'b1;
                  sum       <= '0;
                  cout      <= 1'b0;
                  res_valid <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  carry <= cin_r;
                  idx   <= '0;
                  state <= S_ADD;
               end
            end
            S_ADD: begin
               carry <= dsum[4];
               if (idx == LAST_IDX) begin
                  cout      <= dsum[4];
                  res_valid <= 1'b1;
                  state     <= S_DONE;
`ifdef BCD_SERIAL_SAT_EN
                  sum <= dsum[4] ? all_nines() : sum_next;
`else
                  sum <= sum_next;
`endif
               end else begin
                  sum <= sum_next;
                  idx <= idx + 1'b1;
               end
            end
            default: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed bench for bcd_serial_adder (DIGITS=4); expectations follow BCD_SERIAL_SAT_EN if defined.
module tb_bcd_serial_adder;

   logic        clk;
   logic        rst_n;
   logic        start_valid;
   logic        start_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] sum;
   logic        cout;
   logic        err;
   logic        busy;

   int passed = 0;
   int total  = 0;

   bcd_serial_adder #(.DIGITS(4)) dut (
      .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
      .a(a), .b(b), .cin(cin), .res_valid(res_valid), .res_ready(res_ready),
      .sum(sum), .cout(cout), .err(err), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Accept operands, wait for res_valid (bounded), check result and latency, then hand-shake.
   task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic vc, input logic [15:0] es, input logic ec,
                         input logic ee, input int elat);
      int n;
      @(negedge clk);
      a = va; b = vb; cin = vc; start_valid = 1'b1;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
      n = 1;
      while (res_valid !== 1'b1 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({tag, "_lat"}, n, elat);
      chk({tag, "_sum"}, sum, es);
      chk({tag, "_cout"}, cout, ec);
      chk({tag, "_err"}, err, ee);
      @(negedge clk);
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      chk({tag, "_rv_clr"}, res_valid, 1'b0);
      chk({tag, "_sr"}, start_ready, 1'b1);
   endtask

   initial begin
      logic [15:0] ovf_sum;
      logic [15:0] held_sum;
      logic        held_cout;
`ifdef BCD_SERIAL_SAT_EN
      ovf_sum = 16'h9999;
`else
      ovf_sum = 16'h0000;
`endif
      rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0;
      #12;
      chk("rst_sum", sum, 16'h0);
      chk("rst_rv", res_valid, 1'b0);
      chk("rst_sr", start_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_cout", cout, 1'b0);
      chk("rst_err", err, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("plain",   16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 6);
      run_op("ovf",     16'h9999, 16'h0001, 1'b0, ovf_sum,  1'b1, 1'b0, 6);
      run_op("cin_rip", 16'h0009, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b0, 6);
      run_op("bad_a",   16'h12A4, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 2);
      run_op("after",   16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 6);
      run_op("bad_b",   16'h0001, 16'hF000, 1'b1, 16'h0000, 1'b0, 1'b1, 2);
      run_op("mid_c",   16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 6);
      run_op("cin_ovf", 16'h9999, 16'h0000, 1'b1, ovf_sum,  1'b1, 1'b0, 6);
      run_op("half",    16'h5000, 16'h5000, 1'b1, (ovf_sum == 16'h9999) ? 16'h9999 : 16'h0001,
             1'b1, 1'b0, 6);

      // Back-pressure: result held while new operands are offered.
      @(negedge clk);
      a = 16'h4321; b = 16'h1111; cin = 1'b0; start_valid = 1'b1;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("bp_rv0", res_valid, 1'b1);
      chk("bp_sum0", sum, 16'h5432);
      held_sum = sum;
      held_cout = cout;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         a = 16'h0100 + 16'(i); b = 16'h0002; start_valid = i[0];
         @(posedge clk);
         #1;
         chk("bp_rv", res_valid, 1'b1);
         chk("bp_sum", sum, held_sum);
         chk("bp_cout", cout, held_cout);
         chk("bp_sr", start_ready, 1'b0);
      end
      @(negedge clk);
      start_valid = 1'b0;
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      chk("bp_rel_sr", start_ready, 1'b1);
      chk("bp_rel_rv", res_valid, 1'b0);
      @(posedge clk);
      #1;
      chk("bp_no_start", busy, 1'b0);

      // Reset asserted mid-ADD, checked before any further clock edge.
      @(negedge clk);
      a = 16'h2222; b = 16'h3333; cin = 1'b0; start_valid = 1'b1;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("mid_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_sum", sum, 16'h0);
      chk("mid_rst_rv", res_valid, 1'b0);
      chk("mid_rst_sr", start_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("post_rst", 16'h0458, 16'h0367, 1'b0, 16'h0825, 1'b0, 1'b0, 6);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
